stopwatch_ctrl: RTL and testbench

Control sequencer for the seconds-counter / seven-segment stopwatch datapath. It turns raw start/pause/clear buttons into clean one-cycle commands and runs a four-state FSM (IDLE/RUN/PAUSE/DONE). It owns the clock prescaler and issues the single-cycle `tick` increment enable and `cnt_clr` clear strobe to the counter datapath. It stops the run when the datapath count reaches its limit.

---
 rtl/stopwatch_ctrl.sv | 128 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/edge-detect, IDLE/RUN/PAUSE/DONE FSM, tick prescaler.
// Latency: button to state/cnt_clr is 3 edges; all outputs registered; no backpressure.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 7,
    parameter int CNT_MAX  = 99
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             btn_clr,
    input  logic [CNT_W-1:0] count_in,
    output logic             tick,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             running,
    output logic             done
);

    localparam int         PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic [2:0]    sync1, sync2, sync3;
    logic [2:0]    pulse;
    logic          start_p, pause_p, clr_p;
    logic          at_max;

    // Bit order {clr, pause, start}; sync3 is the edge detector's history flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {btn_clr, btn_pause, btn_start};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pulse   = sync2 & ~sync3;
    assign start_p = pulse[0];
    assign pause_p = pulse[1];
    assign clr_p   = pulse[2];
    assign at_max  = (count_in == CNT_W'(CNT_MAX));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st      <= IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            cnt_clr <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick    <= 1'b0;
            cnt_clr <= 1'b0;
            if (clr_p) begin
                st      <= IDLE;
                presc   <= '0;
                cnt_clr <= 1'b1;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        presc <= '0;
                        if (start_p) begin
                            st      <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A pause on the terminal cycle still lets the tick through.
                        if (presc == TERM) begin
                            presc <= '0;
                            if (at_max) begin
                                st      <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                tick <= 1'b1;
                                if (pause_p) begin
                                    st      <= PAUSE;
                                    running <= 1'b0;
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                            if (pause_p) begin
                                st      <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_p || pause_p) begin
                            st      <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        presc <= '0;
                    end
                    default: begin
                        st      <= IDLE;
                        presc   <= '0;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle scoreboard plus directed latency/spacing checks.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int CM = 3;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_pause = 1'b0;
    logic          btn_clr = 1'b0;
    logic [CW-1:0] count_in;
    logic          tick, cnt_clr, running, done;
    logic [1:0]    state;

    int n_vec = 0;
    int n_bad = 0;

    logic [5:0] exp_q[$];
    int         gap_q[$];
    int         n_tick = 0, n_clr = 0, n_trans = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .CNT_W(CW), .CNT_MAX(CM)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .btn_clr   (btn_clr),
        .count_in  (count_in),
        .tick      (tick),
        .cnt_clr   (cnt_clr),
        .state     (state),
        .running   (running),
        .done      (done)
    );

    // Datapath stand-in: counts on tick, zeroes on cnt_clr.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)       count_in <= '0;
        else if (cnt_clr) count_in <= '0;
        else if (tick)    count_in <= count_in + 1'b1;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: expected {state, running, done, tick, cnt_clr} after each rising edge.
    initial begin : ref_model
        logic [1:0] ms;
        int         mp;
        logic [2:0] h0, h1, h2, pls;
        logic       et, ec;
        ms = 2'd0; mp = 0; h0 = '0; h1 = '0; h2 = '0;
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) begin
                ms = 2'd0; mp = 0; h0 = '0; h1 = '0; h2 = '0;
                if (clk) exp_q.push_back(6'd0);
            end else begin
                pls = h1 & ~h2;
                h2 = h1;
                h1 = h0;
                h0 = {btn_clr, btn_pause, btn_start};
                et = 1'b0;
                ec = 1'b0;
                if (pls[2]) begin
                    ms = 2'd0; mp = 0; ec = 1'b1;
                end else if (ms == 2'd0) begin
                    if (pls[0]) ms = 2'd1;
                end else if (ms == 2'd1) begin
                    if (mp == TD - 1) begin
                        mp = 0;
                        if (int'(count_in) == CM) ms = 2'd3;
                        else begin
                            et = 1'b1;
                            if (pls[1]) ms = 2'd2;
                        end
                    end else begin
                        mp = mp + 1;
                        if (pls[1]) ms = 2'd2;
                    end
                end else if (ms == 2'd2) begin
                    if (pls[0] || pls[1]) ms = 2'd1;
                end
                exp_q.push_back({ms, ms == 2'd1, ms == 2'd3, et, ec});
            end
        end
    end

    initial begin : scoreboard
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("cycle", {2'b00, state, running, done, tick, cnt_clr}, {2'b00, e});
            end
        end
    end

    // Counts RUN cycles between consecutive ticks, plus strobe and transition totals.
    initial begin : monitor
        int         run_cnt;
        logic       armed;
        logic [1:0] prev_st;
        run_cnt = 0; armed = 1'b0; prev_st = 2'd0;
        forever begin
            @(negedge clk);
            if (!clr_n || state == 2'd0 || state == 2'd3) begin
                armed = 1'b0;
                run_cnt = 0;
            end else begin
                if (tick) begin
                    if (armed) gap_q.push_back(run_cnt);
                    armed = 1'b1;
                    run_cnt = 0;
                end
                if (state == 2'd1) run_cnt++;
            end
            if (tick) n_tick++;
            if (cnt_clr) n_clr++;
            if (state != prev_st) n_trans++;
            prev_st = state;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int tick_base, clr_base, trans_base;

        step(3);
        check_val("rst_state", {6'd0, state}, 8'd0);
        check_val("rst_tick", {7'd0, tick}, 8'd0);
        check_val("rst_cnt_clr", {7'd0, cnt_clr}, 8'd0);
        check_val("rst_running", {7'd0, running}, 8'd0);
        check_val("rst_done", {7'd0, done}, 8'd0);
        #2 clr_n = 1'b1;
        step(2);

        tick_base = n_tick;
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        check_val("start_early", {6'd0, state}, 8'd0);
        step(1);
        check_val("start_run", {6'd0, state}, 8'd1);
        check_val("start_running", {7'd0, running}, 8'd1);
        step(3);
        check_val("tick_early", {7'd0, tick}, 8'd0);
        step(1);
        check_val("tick_first", {7'd0, tick}, 8'd1);

        step(2);
        btn_pause = 1'b1;
        step(1);
        btn_pause = 1'b0;
        step(1);
        check_val("tick_second", {7'd0, tick}, 8'd1);
        step(1);
        check_val("pause_enter", {6'd0, state}, 8'd2);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_val("pause_no_tick", {7'd0, tick}, 8'd0);
        end
        btn_pause = 1'b1;
        step(1);
        btn_pause = 1'b0;
        step(1);
        check_val("resume_early", {6'd0, state}, 8'd2);
        step(1);
        check_val("resume_run", {6'd0, state}, 8'd1);
        step(2);
        check_val("resume_wait", {7'd0, tick}, 8'd0);
        step(1);
        check_val("resume_tick", {7'd0, tick}, 8'd1);

        step(4);
        check_val("done_state", {6'd0, state}, 8'd3);
        check_val("done_flag", {7'd0, done}, 8'd1);
        check_val("done_no_tick", {7'd0, tick}, 8'd0);
        check_val("tick_total", 8'(n_tick - tick_base), 8'd3);
        check_val("count_final", {1'b0, count_in}, 8'(CM));

        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
        btn_pause = 1'b1;
        step(1);
        btn_pause = 1'b0;
        step(5);
        check_val("done_ignore", {6'd0, state}, 8'd3);

        btn_clr = 1'b1;
        step(1);
        btn_clr = 1'b0;
        step(1);
        check_val("clr_early", {7'd0, cnt_clr}, 8'd0);
        step(1);
        check_val("clr_strobe", {7'd0, cnt_clr}, 8'd1);
        check_val("clr_state", {6'd0, state}, 8'd0);
        step(1);
        check_val("clr_width", {7'd0, cnt_clr}, 8'd0);
        check_val("clr_count", {1'b0, count_in}, 8'd0);

        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
        step(2);
        check_val("sim_pre_run", {6'd0, state}, 8'd1);
        clr_base = n_clr;
        btn_clr = 1'b1;
        btn_start = 1'b1;
        step(1);
        btn_clr = 1'b0;
        btn_start = 1'b0;
        step(2);
        check_val("clr_start_state", {6'd0, state}, 8'd0);
        check_val("clr_start_strobe", {7'd0, cnt_clr}, 8'd1);
        step(2);
        check_val("clr_start_once", 8'(n_clr - clr_base), 8'd1);

        btn_start = 1'b1;
        btn_pause = 1'b1;
        step(1);
        btn_start = 1'b0;
        btn_pause = 1'b0;
        step(2);
        check_val("start_pause_state", {6'd0, state}, 8'd1);
        step(3);
        check_val("start_pause_hold", {6'd0, state}, 8'd1);

        trans_base = n_trans;
        btn_pause = 1'b1;
        step(20);
        check_val("held_state", {6'd0, state}, 8'd2);
        btn_pause = 1'b0;
        step(4);
        check_val("held_once", 8'(n_trans - trans_base), 8'd1);
        check_val("held_final", {6'd0, state}, 8'd2);

        btn_pause = 1'b1;
        step(1);
        btn_pause = 1'b0;
        step(4);
        check_val("async_pre", {6'd0, state}, 8'd1);
        #2 clr_n = 1'b0;
        #1;
        check_val("async_outs", {2'b00, state, running, done, tick, cnt_clr}, 8'd0);
        step(2);
        #2 clr_n = 1'b1;
        step(5);
        check_val("post_rst_idle", {6'd0, state}, 8'd0);
        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
        step(2);
        check_val("restart", {6'd0, state}, 8'd1);
        step(3);

        check_val("gap_count", {7'd0, gap_q.size() >= 2}, 8'd1);
        foreach (gap_q[i]) check_val("tick_gap", 8'(gap_q[i]), 8'(TD));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
